// File: rtl/mp3_pkg.sv
// Shared constants and types for the mp3 player control path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mp3_pkg;

    // Single-byte ASCII commands arriving over the Bluetooth UART link
    localparam logic [7:0] CMD_NEXT  = 8'h4E;  // 'N'
    localparam logic [7:0] CMD_PRE   = 8'h42;  // 'B'
    localparam logic [7:0] CMD_PAUSE = 8'h50;  // 'P'
    localparam logic [7:0] CMD_VUP   = 8'h2B;  // '+'
    localparam logic [7:0] CMD_VDN   = 8'h2D;  // '-'

    // Quietest volume level; level 0 is the loudest
    localparam int VOL_MAX_LVL = 8;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    typedef enum logic {
        DEC_RUN,
        DEC_HOLD
    } dec_state_t;

    // Per-channel attenuation byte for a volume level
    function automatic logic [7:0] vol_att(input logic [3:0] lvl, input logic [7:0] step);
        return {4'd0, lvl} * step;
    endfunction

endpackage

// File: rtl/bt_cmd_decoder_uart_rx.sv
// UART 8N1 receiver: 2-FF synchroniser, mid-bit sampling, one-cycle byte / frame-error strobes.
// Latency: o_valid rises 1 clk after the stop bit is sampled (about 9.5 bit times after the start edge + 3 clk).
// Backpressure: none; the strobe is not held, the consumer must take it in the cycle it is high.
// Ports: clk, rst_n (async active-low), rx (async, idles high) -> o_data[7:0], o_valid, o_frame_err.
module uart_rx_8n1
    import mp3_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

    logic            r_sync1, r_sync2, r_rx_prev;
    rx_state_t       r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [2:0]      r_bit_idx, w_bit_idx_nxt;
    logic [7:0]      r_shift, w_shift_nxt;
    logic            r_valid, w_valid_nxt;
    logic            r_ferr, w_ferr_nxt;
    logic            w_fall;

    // Synchroniser resets to the idle level so release never looks like a start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    assign w_fall = r_rx_prev & ~r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RX_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_valid   <= w_valid_nxt;
            r_ferr    <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_valid_nxt   = 1'b0;
        w_ferr_nxt    = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = RX_START;
                    w_cnt_nxt   = '0;
                end
            end
            RX_START: begin
                // Half a bit in: a line that is high again was only a glitch
                if (r_cnt == HALF_M1) begin
                    w_cnt_nxt     = '0;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = r_sync2 ? RX_IDLE : RX_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            RX_DATA: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {r_sync2, r_shift[7:1]};  // LSB first
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = RX_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            RX_STOP: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt_nxt = '0;
                    if (r_sync2) begin
                        w_valid_nxt = 1'b1;
                        w_state_nxt = RX_IDLE;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = RX_WAIT_HIGH;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            RX_WAIT_HIGH: begin
                // A held-low line (break) must not re-trigger framing, so wait for idle
                if (r_sync2) begin
                    w_state_nxt = RX_IDLE;
                end
            end
            default: begin
                w_state_nxt = RX_IDLE;
            end
        endcase
    end

    assign o_data      = r_shift;
    assign o_valid     = r_valid;
    assign o_frame_err = r_ferr;

endmodule

// File: rtl/bt_cmd_decoder.sv
// Bluetooth UART command decoder: turns ASCII command bytes and song-finished pulses into player state.
// Latency: state and pulses update 1 clk after the receiver strobe; a byte colliding with i_finish_song lands 1 clk later.
// Backpressure: none; at most one pending byte is held while a simultaneous finish pulse is applied.
// Ports: clk, rst_n, rx, i_finish_song -> o_vol, o_vol_level, o_song_select, o_pause,
//        o_next, o_pre, o_vol_plus, o_vol_dec, o_frame_err (all pulses one cycle wide).
module bt_cmd_decoder #(
    parameter int         CLK_HZ      = 100_000_000,
    parameter int         BAUD        = 9600,
    parameter int         NUM_SONGS   = 4,
    parameter logic [7:0] VOL_STEP    = 8'h10,
    parameter int         VOL_MAX_LVL = mp3_pkg::VOL_MAX_LVL,
    parameter int         VOL_RST_LVL = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    input  logic        i_finish_song,
    output logic [15:0] o_vol,
    output logic [3:0]  o_vol_level,
    output logic [2:0]  o_song_select,
    output logic        o_pause,
    output logic        o_next,
    output logic        o_pre,
    output logic        o_vol_plus,
    output logic        o_vol_dec,
    output logic        o_frame_err
);

    import mp3_pkg::*;

    localparam logic [3:0] LVL_MAX   = 4'(VOL_MAX_LVL);
    localparam logic [3:0] LVL_RST   = 4'(VOL_RST_LVL);
    localparam logic [2:0] SONG_LAST = 3'(NUM_SONGS - 1);

    logic [7:0]  w_rx_data;
    logic        w_rx_valid;
    logic        w_rx_ferr;

    dec_state_t  r_state, w_state_nxt;
    logic [7:0]  r_hold, w_hold_nxt;
    logic        w_apply;
    logic [7:0]  w_byte;

    logic [2:0]  r_song, w_song_nxt;
    logic [3:0]  r_level, w_level_nxt;
    logic        r_pause, w_pause_nxt;
    logic        r_next, w_next_nxt;
    logic        r_pre, w_pre_nxt;
    logic        r_vup, w_vup_nxt;
    logic        r_vdn, w_vdn_nxt;
    logic [15:0] r_vol;
    logic [7:0]  w_att_nxt;

    uart_rx_8n1 #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .o_data      (w_rx_data),
        .o_valid     (w_rx_valid),
        .o_frame_err (w_rx_ferr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= DEC_RUN;
            r_hold  <= '0;
            r_song  <= '0;
            r_level <= LVL_RST;
            r_pause <= 1'b0;
            r_next  <= 1'b0;
            r_pre   <= 1'b0;
            r_vup   <= 1'b0;
            r_vdn   <= 1'b0;
            r_vol   <= {2{vol_att(LVL_RST, VOL_STEP)}};
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_song  <= w_song_nxt;
            r_level <= w_level_nxt;
            r_pause <= w_pause_nxt;
            r_next  <= w_next_nxt;
            r_pre   <= w_pre_nxt;
            r_vup   <= w_vup_nxt;
            r_vdn   <= w_vdn_nxt;
            r_vol   <= {w_att_nxt, w_att_nxt};
        end
    end

    // Arbitration: a finish pulse always wins the cycle; a byte arriving alongside it is parked
    // in r_hold and applied on the first cycle without a finish pulse.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_apply     = 1'b0;
        w_byte      = w_rx_data;
        case (r_state)
            DEC_RUN: begin
                if (i_finish_song) begin
                    if (w_rx_valid) begin
                        w_hold_nxt  = w_rx_data;
                        w_state_nxt = DEC_HOLD;
                    end
                end else if (w_rx_valid) begin
                    w_apply = 1'b1;
                end
            end
            DEC_HOLD: begin
                if (!i_finish_song) begin
                    w_apply     = 1'b1;
                    w_byte      = r_hold;
                    w_state_nxt = DEC_RUN;
                end
            end
            default: begin
                w_state_nxt = DEC_RUN;
            end
        endcase
    end

    // Command effects
    always_comb begin
        w_song_nxt  = r_song;
        w_level_nxt = r_level;
        w_pause_nxt = r_pause;
        w_next_nxt  = 1'b0;
        w_pre_nxt   = 1'b0;
        w_vup_nxt   = 1'b0;
        w_vdn_nxt   = 1'b0;
        if (i_finish_song) begin
            w_song_nxt  = (r_song == SONG_LAST) ? 3'd0 : r_song + 3'd1;
            w_pause_nxt = 1'b0;
            w_next_nxt  = 1'b1;
        end else if (w_apply) begin
            case (w_byte)
                CMD_NEXT: begin
                    w_song_nxt  = (r_song == SONG_LAST) ? 3'd0 : r_song + 3'd1;
                    w_pause_nxt = 1'b0;
                    w_next_nxt  = 1'b1;
                end
                CMD_PRE: begin
                    w_song_nxt  = (r_song == 3'd0) ? SONG_LAST : r_song - 3'd1;
                    w_pause_nxt = 1'b0;
                    w_pre_nxt   = 1'b1;
                end
                CMD_PAUSE: begin
                    w_pause_nxt = ~r_pause;
                end
                CMD_VUP: begin
                    if (r_level != 4'd0) begin
                        w_level_nxt = r_level - 4'd1;
                        w_vup_nxt   = 1'b1;
                    end
                end
                CMD_VDN: begin
                    if (r_level < LVL_MAX) begin
                        w_level_nxt = r_level + 4'd1;
                        w_vdn_nxt   = 1'b1;
                    end
                end
                default: begin
                    // ASCII '0'..'7' share the upper bits 00110; the low 3 bits are the index
                    if ((w_byte[7:3] == 5'b00110) && (int'(w_byte[2:0]) < NUM_SONGS)) begin
                        w_song_nxt  = w_byte[2:0];
                        w_pause_nxt = 1'b0;
                        w_next_nxt  = (w_byte[2:0] != r_song);
                    end
                end
            endcase
        end
    end

    // Volume word tracks the next level so it changes in the same cycle as o_vol_level
    assign w_att_nxt = vol_att(w_level_nxt, VOL_STEP);

    assign o_vol         = r_vol;
    assign o_vol_level   = r_level;
    assign o_song_select = r_song;
    assign o_pause       = r_pause;
    assign o_next        = r_next;
    assign o_pre         = r_pre;
    assign o_vol_plus    = r_vup;
    assign o_vol_dec     = r_vdn;
    assign o_frame_err   = w_rx_ferr;

endmodule
